// File: rtl/imem_loader_if.sv
// Loader-facing bundle: session control, source stream,
// instruction memory port and status.
interface imem_loader_if;
    logic        start;
    logic [5:0]  length;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_write_enable;
    logic        mem_mode;
    logic [4:0]  mem_PC;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    modport slave (
        input  start,
        input  length,
        input  in_valid,
        input  in_data,
        input  mem_data_out,
        output in_ready,
        output mem_write_enable,
        output mem_mode,
        output mem_PC,
        output mem_data_in,
        output busy,
        output done,
        output error,
        output checksum
    );

    modport master (
        output start,
        output length,
        output in_valid,
        output in_data,
        output mem_data_out,
        input  in_ready,
        input  mem_write_enable,
        input  mem_mode,
        input  mem_PC,
        input  mem_data_in,
        input  busy,
        input  done,
        input  error,
        input  checksum
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: streams a session of words into a
// 32x32 memory, then reads them back and checks the XOR sum.
module imem_loader (
    input  logic         clock,
    input  logic         reset,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERIFY,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    logic [5:0]  len_q;
    logic [4:0]  addr_q;
    logic [5:0]  vcnt_q;
    logic [31:0] cks_q;
    logic [31:0] acc_q;

    logic        len_ok;
    logic [5:0]  len_m1;
    logic        last_word;
    logic        vlast;
    logic [31:0] acc_nxt;
    logic [4:0]  rd_pc;

    assign len_ok    = (bus.length != 6'd0)
                    && (bus.length <= 6'd32);
    assign len_m1    = len_q - 6'd1;
    assign last_word = ({1'b0, addr_q} == len_m1);
    assign vlast     = (vcnt_q == len_q);
    assign acc_nxt   = acc_q ^ bus.mem_data_out;
    // Read address walks 0..len-1, then parks on the last word
    // while the final readback arrives.
    assign rd_pc     = (vcnt_q < len_q) ? vcnt_q[4:0]
                                        : len_m1[4:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            len_q  <= 6'd0;
            addr_q <= 5'd0;
            vcnt_q <= 6'd0;
            cks_q  <= 32'd0;
            acc_q  <= 32'd0;
        end else begin
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        if (len_ok) begin
                            state  <= LOAD;
                            len_q  <= bus.length;
                            addr_q <= 5'd0;
                            cks_q  <= 32'd0;
                        end else begin
                            state <= ERROR;
                        end
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        cks_q <= cks_q ^ bus.in_data;
                        if (last_word) begin
                            state  <= VERIFY;
                            vcnt_q <= 6'd0;
                            acc_q  <= 32'd0;
                        end else begin
                            addr_q <= addr_q + 5'd1;
                        end
                    end
                end
                VERIFY: begin
                    vcnt_q <= vcnt_q + 6'd1;
                    // Readback lags the address by one cycle.
                    if (vcnt_q != 6'd0) begin
                        acc_q <= acc_nxt;
                    end
                    if (vlast) begin
                        state <= (acc_nxt == cks_q) ? DONE
                                                    : ERROR;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.in_ready         = 1'b0;
        bus.mem_write_enable = 1'b0;
        bus.mem_mode         = 1'b1;
        bus.mem_PC           = 5'd0;
        bus.mem_data_in      = bus.in_data;
        unique case (state)
            LOAD: begin
                bus.in_ready         = 1'b1;
                bus.mem_mode         = 1'b0;
                bus.mem_PC           = addr_q;
                bus.mem_write_enable = bus.in_valid;
            end
            VERIFY: begin
                bus.mem_PC = rd_pc;
            end
            default: begin
                bus.mem_PC = 5'd0;
            end
        endcase
    end

    assign bus.busy     = (state == LOAD) || (state == VERIFY);
    assign bus.done     = (state == DONE);
    assign bus.error    = (state == ERROR);
    assign bus.checksum = cks_q;
endmodule
